// File: rtl/xform_pkg.sv
// Shared types and helpers for the xform_engine datapath.
// Optional XFORM_PARITY_EN adds a registered parity output on the top.
package xform_pkg;

  localparam int ROUNDS_W = 8;
  // Upper bound on datapath width accepted by the generic byte-swap helper.
  localparam int MAX_DW   = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ROL   = 2'd0,
    ROR   = 2'd1,
    INV   = 2'd2,
    BSWAP = 2'd3
  } op_t;

  typedef struct packed {
    op_t                 op;
    logic [ROUNDS_W-1:0] rounds;
    logic                err;
  } status_t;

  // Reverses the order of the low nbytes bytes of d; upper bytes return zero.
  function automatic logic [MAX_DW-1:0] bswap(input logic [MAX_DW-1:0] d, input int nbytes);
    logic [MAX_DW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DW / 8; i++) begin
      if (i < nbytes) r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/xform_mem.sv
// Byte-enable scratch RAM with a registered read port; a same-address
// read during a write returns the previous contents.
module xform_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_o <= '0;
    else         rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/xform_engine.sv
// Back-pressured byte-merge / multi-round transform engine with scratch RAM.
// Define XFORM_PARITY_EN to add the registered parity_o output.
//
// state | meaning
// IDLE  | ready for a job; held word seeds the next merge
// RUN   | applying one round of the latched op per cycle
// HOLD  | result presented until the consumer takes it
module xform_engine
  import xform_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 6,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic [DATA_WIDTH/8-1:0] in_be_i,
  input  op_t                     in_op_i,
  input  logic [ROUNDS_W-1:0]     in_rounds_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output status_t                 out_status_o,
  input  logic                    flush_i,
  output logic                    err_o,
  input  logic                    err_clr_i,
  output logic                    busy_o,
  input  logic                    mem_we_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_be_i,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o
`ifdef XFORM_PARITY_EN
  ,
  output logic                    parity_o
`endif
);

  localparam int NB = DATA_WIDTH / 8;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] held_q, held_d;
  logic [DATA_WIDTH-1:0] merged, stepped;
  logic [MAX_DW-1:0]     held_ext, held_swapped;
  op_t                   op_q;
  logic [ROUNDS_W-1:0]   rounds_q, cnt_q, cnt_d;
  logic                  err_q, err_d, st_err_q;
  logic                  accept, abort, enter_hold;

  always_comb begin
    merged = held_q;
    for (int k = 0; k < NB; k++) begin
      if (in_be_i[k]) merged[8*k +: 8] = in_data_i[8*k +: 8];
    end
  end

  always_comb begin
    held_ext                     = '0;
    held_ext[DATA_WIDTH-1:0]     = held_q;
    held_swapped                 = bswap(held_ext, NB);
    stepped                      = held_q;
    case (op_q)
      ROL:     stepped = {held_q[DATA_WIDTH-2:0], held_q[DATA_WIDTH-1]};
      ROR:     stepped = {held_q[0], held_q[DATA_WIDTH-1:1]};
      INV:     stepped = ~held_q;
      BSWAP:   stepped = held_swapped[DATA_WIDTH-1:0];
      default: stepped = held_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          accept  = 1'b1;
          held_d  = merged;
          cnt_d   = '0;
          state_d = (in_rounds_i == '0) ? HOLD : RUN;
        end
      end
      RUN: begin
        // An aborted round is not applied: the held word keeps the last completed round.
        if (flush_i) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          held_d = stepped;
          cnt_d  = cnt_q + ROUNDS_W'(1);
          if (cnt_d == rounds_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end else if (flush_i) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d      = abort ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    enter_hold = (state_q != HOLD) && (state_d == HOLD);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_q   <= RESET_VALUE;
      op_q     <= ROL;
      rounds_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      st_err_q <= 1'b0;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      if (accept) begin
        op_q     <= in_op_i;
        rounds_q <= in_rounds_i;
      end
      if (enter_hold) st_err_q <= err_q;
    end
  end

`ifdef XFORM_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) parity_q <= 1'b0;
    else         parity_q <= ^held_d;
  end
  assign parity_o = parity_q;
`endif

  assign in_ready_o          = (state_q == IDLE);
  assign out_valid_o         = (state_q == HOLD);
  assign busy_o              = (state_q != IDLE);
  assign out_data_o          = held_q;
  assign err_o               = err_q;
  assign out_status_o.op     = op_q;
  assign out_status_o.rounds = rounds_q;
  assign out_status_o.err    = st_err_q;

  xform_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we_i   (mem_we_i),
    .addr_i (mem_addr_i),
    .wdata_i(mem_wdata_i),
    .be_i   (mem_be_i),
    .rdata_o(mem_rdata_o)
  );

endmodule

// File: tb/tb_xform_engine.sv
// Directed plus randomized bench for xform_engine against a behavioural model.
module tb_xform_engine;
  import xform_pkg::*;

  localparam int DW = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic [3:0]    in_be = '0;
  op_t           in_op = ROL;
  logic [7:0]    in_rounds = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_data;
  status_t       out_status;
  logic          flush = 1'b0, err, err_clr = 1'b0, busy;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0, mem_rdata;
  logic [3:0]    mem_be = '0;
`ifdef XFORM_PARITY_EN
  logic          parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_held = '0;
  logic        m_err  = 1'b0;
  logic [31:0] m_mem [8];

  always #5 clk = ~clk;

  xform_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_VALUE('0)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_be_i(in_be),
    .in_op_i(in_op), .in_rounds_i(in_rounds),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_status_o(out_status), .flush_i(flush), .err_o(err), .err_clr_i(err_clr),
    .busy_o(busy), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_be_i(mem_be), .mem_rdata_o(mem_rdata)
`ifdef XFORM_PARITY_EN
    , .parity_o(parity)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] step(input logic [31:0] w, input op_t op);
    case (op)
      ROL:     return (w << 1) | (w >> 31);
      ROR:     return (w >> 1) | (w << 31);
      INV:     return ~w;
      default: return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endcase
  endfunction

  function automatic logic [31:0] ref_apply(input logic [31:0] w, input op_t op, input int n);
    logic [31:0] r = w;
    for (int i = 0; i < n; i++) r = step(r, op);
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] h, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r = h;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic run_job(input string tag, input logic [31:0] d, input logic [3:0] be,
                         input op_t op, input logic [7:0] r, input int stall, input bit flush_xfer);
    logic [31:0] exp;
    int lat;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    exp = ref_apply(merge(m_held, d, be), op, int'(r));
    in_valid = 1'b1; in_data = d; in_be = be; in_op = op; in_rounds = r;
    tick();
    in_valid = 1'b0; in_data = $urandom; in_be = 4'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(r) + 64'd1);
    chk({tag, "_data"}, 64'(out_data), 64'(exp));
    chk({tag, "_status"}, 64'(out_status), 64'({op, r, m_err}));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
`ifdef XFORM_PARITY_EN
    chk({tag, "_parity"}, 64'(parity), 64'(^exp));
`endif
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_stall_data"}, 64'(out_data), 64'(exp));
      chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1; flush = flush_xfer;
    tick();
    out_ready = 1'b0; flush = 1'b0;
    chk({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_post_err"}, 64'(err), 64'(m_err));
    m_held = exp;
  endtask

  initial begin
    logic [31:0] exp_old, d;
    int lat;

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_status", 64'(out_status), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_rdata", 64'(mem_rdata), 64'd0);
`ifdef XFORM_PARITY_EN
    chk("rst_parity", 64'(parity), 64'd0);
`endif
    rst_ni = 1'b1;
    tick();

    run_job("rol1", 32'h8000_0001, 4'hF, ROL, 8'd1, 0, 1'b0);
    run_job("bswap0", 32'hAABB_CCDD, 4'b1100, BSWAP, 8'd0, 0, 1'b0);
    run_job("inv3", 32'h0F0F_0F0F, 4'hF, INV, 8'd3, 5, 1'b0);
    run_job("ror_flushxfer", 32'h1234_5678, 4'hF, ROR, 8'd2, 1, 1'b1);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_err", 64'(err), 64'd0);
    chk("idle_flush_ready", 64'(in_ready), 64'd1);
    chk("idle_flush_busy", 64'(busy), 64'd0);

    // Abort after two completed rounds in RUN.
    d = 32'hC000_0005;
    in_valid = 1'b1; in_data = d; in_be = 4'hF; in_op = ROL; in_rounds = 8'd10;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("run_flush_ready", 64'(in_ready), 64'd1);
    chk("run_flush_valid", 64'(out_valid), 64'd0);
    chk("run_flush_err", 64'(err), 64'd1);
    chk("run_flush_busy", 64'(busy), 64'd0);
    m_err  = 1'b1;
    m_held = ref_apply(d, ROL, 2);
    run_job("peek_run", 32'hDEAD_BEEF, 4'h0, INV, 8'd0, 0, 1'b0);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 64'(err), 64'd0);
    m_err = 1'b0;

    // Abort in HOLD with a simultaneous clear: the set wins and the result is dropped.
    d = 32'h0102_0304;
    in_valid = 1'b1; in_data = d; in_be = 4'b0011; in_op = BSWAP; in_rounds = 8'd1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    chk("hold_flush_latency", 64'(lat), 64'd2);
    m_held = ref_apply(merge(m_held, d, 4'b0011), BSWAP, 1);
    flush = 1'b1; err_clr = 1'b1;
    tick();
    flush = 1'b0; err_clr = 1'b0;
    chk("hold_flush_valid", 64'(out_valid), 64'd0);
    chk("hold_flush_err", 64'(err), 64'd1);
    m_err = 1'b1;
    run_job("peek_hold", 32'h0, 4'h0, ROL, 8'd0, 0, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = 1'b0;
    chk("err_clr2", 64'(err), 64'd0);

    for (int j = 0; j < 20; j++) begin
      run_job("rand", $urandom, 4'($urandom), op_t'($urandom_range(0, 3)),
              8'($urandom_range(0, 6)), $urandom_range(0, 3), 1'b0);
    end
    run_job("rand_long", $urandom, 4'hF, ROR, 8'd40, 0, 1'b0);

    mem_we = 1'b1; mem_addr = 6'd5; mem_wdata = 32'h1122_3344; mem_be = 4'hF;
    tick();
    mem_wdata = 32'hFFFF_FFFF; mem_be = 4'b0001;
    tick();
    chk("mem_rdw_old", 64'(mem_rdata), 64'h1122_3344);
    mem_we = 1'b0;
    tick();
    chk("mem_be_merge", 64'(mem_rdata), 64'h1122_33FF);

    for (int a = 0; a < 8; a++) begin
      m_mem[a] = $urandom;
      mem_we = 1'b1; mem_addr = 6'(a); mem_wdata = m_mem[a]; mem_be = 4'hF;
      tick();
    end
    for (int j = 0; j < 40; j++) begin
      mem_we    = 1'($urandom);
      mem_addr  = 6'($urandom_range(0, 7));
      mem_wdata = $urandom;
      mem_be    = 4'($urandom);
      exp_old   = m_mem[mem_addr[2:0]];
      tick();
      chk("mem_rand", 64'(mem_rdata), 64'(exp_old));
      if (mem_we) m_mem[mem_addr[2:0]] = merge(exp_old, mem_wdata, mem_be);
    end
    mem_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
